// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier: one partial product per enabled cycle, WIDTH cycles per product.
// Optional two's-complement operation is enabled by defining SEQ_MULTIPLIER_SIGNED_EN (adds the signed_mode port).
module seq_multiplier #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
  input  logic                 signed_mode,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Upper half accumulates partial sums; lower half holds the remaining multiplier bits.
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               neg_q, neg_d;

  logic [WIDTH:0]     sum;
  logic [PW-1:0]      prod;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               neg_start;

  // Signed operands are multiplied as magnitudes; the sign is reapplied on completion.
`ifdef SEQ_MULTIPLIER_SIGNED_EN
  always_comb begin
    mag1      = (signed_mode && op1[WIDTH-1]) ? WIDTH'(-op1) : op1;
    mag2      = (signed_mode && op2[WIDTH-1]) ? WIDTH'(-op2) : op2;
    neg_start = signed_mode && (op1[WIDTH-1] ^ op2[WIDTH-1]);
  end
`else
  always_comb begin
    mag1      = op1;
    mag2      = op2;
    neg_start = 1'b0;
  end
`endif

  // One shift-add step.
  always_comb begin
    sum  = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
    prod = {sum, acc_q[WIDTH-1:1]};
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    neg_d    = neg_q;

    if (enable) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            mcand_d = mag1;
            acc_d   = {WIDTH'(0), mag2};
            neg_d   = neg_start;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          acc_d = prod;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = neg_q ? PW'(-prod) : prod;
          end
        end
        default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      neg_q    <= neg_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
